alu_rr_sequencer: RTL and testbench

//  Shares one registered ALU_TOP between NREQ requesters. Each cycle in IDLE it picks one

---
 rtl/alu_rr_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one registered ALU among NREQ requesters.
// One op in flight: IDLE -> ISSUE -> CAPTURE -> RESP; the response waits indefinitely for rsp_ready_i.
module alu_rr_sequencer #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic [NREQ*4-1:0]     req_sel_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]      alu_a_o,
  output logic [WIDTH-1:0]      alu_b_o,
  output logic [3:0]            alu_sel_o,
  input  logic [WIDTH-1:0]      alu_c_i,
  input  logic                  alu_zero_i,
  input  logic                  alu_ovf_i,
  input  logic                  alu_cout_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_zero_o,
  output logic                  rsp_ovf_o,
  output logic                  rsp_cout_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [3:0]       op_sel_q;
  logic [IDW-1:0]   op_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;
  logic             zero_q;
  logic             ovf_q;
  logic             cout_q;

  logic [NREQ-1:0]  grant_oh;
  logic [IDW-1:0]   grant_id;
  logic             any_vld;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    logic [IDW:0] pos;
    logic [IDW-1:0] idx;
    grant_oh = '0;
    grant_id = '0;
    any_vld  = 1'b0;
    pos      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) begin
        pos = pos - (IDW+1)'(NREQ);
      end
      idx = pos[IDW-1:0];
      if (!any_vld && req_valid_i[idx]) begin
        any_vld       = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = idx;
      end
    end
  end

  assign rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      op_id_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_vld) begin
            op_a_q   <= req_a_i[grant_id*WIDTH +: WIDTH];
            op_b_q   <= req_b_i[grant_id*WIDTH +: WIDTH];
            op_sel_q <= req_sel_i[grant_id*4 +: 4];
            op_id_q  <= grant_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Flags are combinational from the ALU inputs, so they belong to this cycle,
          // one cycle ahead of the registered result.
          if (op_sel_q[3:2] == 2'b00) begin
            zero_q <= alu_zero_i;
            ovf_q  <= alu_ovf_i;
            cout_q <= alu_cout_i;
          end else begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
          end
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_data_q  <= alu_c_i;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE && !rst_i) ? grant_oh : '0;
  assign alu_a_o     = op_a_q;
  assign alu_b_o     = op_b_q;
  assign alu_sel_o   = op_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = op_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_zero_o  = zero_q;
  assign rsp_ovf_o   = ovf_q;
  assign rsp_cout_o  = cout_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench for alu_rr_sequencer with a behavioural registered ALU attached.
module tb_alu_rr_sequencer;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*WIDTH-1:0] req_a_i, req_b_i;
  logic [NREQ*4-1:0]     req_sel_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [WIDTH-1:0]      alu_a_o, alu_b_o;
  logic [3:0]            alu_sel_o;
  logic [WIDTH-1:0]      alu_c_i;
  logic                  alu_zero_i, alu_ovf_i, alu_cout_i;
  logic                  rsp_valid_o, rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [WIDTH-1:0]      rsp_data_o;
  logic                  rsp_zero_o, rsp_ovf_o, rsp_cout_o;

  alu_rr_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_sel_i(req_sel_i), .req_ready_o(req_ready_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_sel_o(alu_sel_o),
    .alu_c_i(alu_c_i), .alu_zero_i(alu_zero_i), .alu_ovf_i(alu_ovf_i),
    .alu_cout_i(alu_cout_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .rsp_ovf_o(rsp_ovf_o),
    .rsp_cout_o(rsp_cout_o)
  );

  always #5 clk_i = ~clk_i;

  // ALU: 0000 ADD, 0001 SUB, 0100 AND, 0101 OR, else XOR. Logic ops drive junk OVF/COUT.
  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_wide   = '0;
    alu_res    = '0;
    alu_zero_i = 1'b0;
    alu_ovf_i  = 1'b0;
    alu_cout_i = 1'b0;
    case (alu_sel_o)
      4'b0000: alu_wide = {1'b0, alu_a_o} + {1'b0, alu_b_o};
      4'b0001: alu_wide = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + 9'd1;
      4'b0100: alu_wide = {1'b0, alu_a_o & alu_b_o};
      4'b0101: alu_wide = {1'b0, alu_a_o | alu_b_o};
      default: alu_wide = {1'b0, alu_a_o ^ alu_b_o};
    endcase
    alu_res    = alu_wide[WIDTH-1:0];
    alu_zero_i = (alu_res == '0);
    if (alu_sel_o[3:2] == 2'b00) begin
      alu_cout_i = alu_wide[WIDTH];
      if (alu_sel_o == 4'b0000)
        alu_ovf_i = (alu_a_o[7] == alu_b_o[7]) && (alu_res[7] != alu_a_o[7]);
      else
        alu_ovf_i = (alu_a_o[7] != alu_b_o[7]) && (alu_res[7] != alu_a_o[7]);
    end else begin
      alu_ovf_i  = 1'b1;
      alu_cout_i = 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) alu_c_i <= '0;
    else       alu_c_i <= alu_res;
  end

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             z;
    logic             o;
    logic             c;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t rr_exp[4];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted response is compared with the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0h data %0h, expected no response", rsp_id_o, rsp_data_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_id_o), 32'(mon_e.id));
        chk("rsp_data", 32'(rsp_data_o), 32'(mon_e.data));
        chk("rsp_zero", 32'(rsp_zero_o), 32'(mon_e.z));
        chk("rsp_ovf", 32'(rsp_ovf_o), 32'(mon_e.o));
        chk("rsp_cout", 32'(rsp_cout_o), 32'(mon_e.c));
      end
    end
  end

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    req_a_i[id*WIDTH +: WIDTH] = a;
    req_b_i[id*WIDTH +: WIDTH] = b;
    req_sel_i[id*4 +: 4]       = sel;
  endtask

  // Returns at the negedge of the cycle in which requester id is granted (or on timeout).
  task automatic wait_grant(input int id, input string name);
    int n = 0;
    @(negedge clk_i);
    while (req_ready_o[id] !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, 32'(req_ready_o), 32'(1) << id);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input exp_t e, input string name);
    @(posedge clk_i); #1;
    set_op(id, a, b, sel);
    req_valid_i[id] = 1'b1;
    wait_grant(id, name);
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    req_valid_i[id] = 1'b0;
    drain({name, "_drain"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int lat;
    int n;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    req_sel_i   = '0;
    rsp_ready_i = 1'b0;
    rr_exp[0] = {2'd0, 8'h03, 1'b0, 1'b0, 1'b0};
    rr_exp[1] = {2'd1, 8'h30, 1'b0, 1'b0, 1'b0};
    rr_exp[2] = {2'd2, 8'h80, 1'b0, 1'b1, 1'b0};
    rr_exp[3] = {2'd3, 8'h00, 1'b1, 1'b0, 1'b1};
    set_op(0, 8'h01, 8'h02, 4'b0000);
    set_op(1, 8'h10, 8'h20, 4'b0000);
    set_op(2, 8'h7F, 8'h01, 4'b0000);
    set_op(3, 8'hFF, 8'h01, 4'b0000);
    req_valid_i = 4'b1111;

    // Reset state with every requester already valid.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_req_ready", 32'(req_ready_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_alu_a", 32'(alu_a_o), 32'd0);
    chk("reset_alu_sel", 32'(alu_sel_o), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data_o), 32'd0);
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Round-robin with all requesters held valid.
    prev = -1;
    for (int g = 0; g < 5; g++) begin
      wait_grant(g % 4, "rr_grant");
      if (prev >= 0) chk("rr_spacing", 32'(cyc - prev), 32'd4);
      prev = cyc;
      sb_q.push_back(rr_exp[g % 4]);
    end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    drain("rr_drain");

    // Single ADD: grant at cycle 0, response at cycle 3.
    @(posedge clk_i); #1;
    set_op(0, 8'hF0, 8'h20, 4'b0000);
    req_valid_i = 4'b0001;
    @(negedge clk_i);
    chk("single_ready", 32'(req_ready_o), 32'b0001);
    sb_q.push_back({2'd0, 8'h10, 1'b0, 1'b0, 1'b1});
    @(posedge clk_i); #1;
    req_valid_i = '0;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!rsp_valid_o && lat < 20);
    chk("single_latency", 32'(lat), 32'd3);
    drain("single_drain");
    chk("alu_hold_a", 32'(alu_a_o), 32'hF0);
    chk("alu_hold_b", 32'(alu_b_o), 32'h20);

    // Backpressure: response held 5 cycles while req3 waits.
    rsp_ready_i = 1'b0;
    @(posedge clk_i); #1;
    set_op(2, 8'h33, 8'h11, 4'b0000);
    req_valid_i = 4'b0100;
    wait_grant(2, "bp_grant");
    sb_q.push_back({2'd2, 8'h44, 1'b0, 1'b0, 1'b0});
    @(posedge clk_i); #1;
    set_op(3, 8'h01, 8'h01, 4'b0000);
    req_valid_i = 4'b1000;
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_data", 32'(rsp_data_o), 32'h44);
      chk("bp_id", 32'(rsp_id_o), 32'd2);
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_hs_req_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    chk("bp_next_grant", 32'(req_ready_o), 32'b1000);
    sb_q.push_back({2'd3, 8'h02, 1'b0, 1'b0, 1'b0});
    @(posedge clk_i); #1;
    req_valid_i = '0;
    drain("bp_drain");

    // Reset during CAPTURE: op dropped, pointer back to 0.
    @(posedge clk_i); #1;
    set_op(1, 8'h11, 8'h22, 4'b0000);
    req_valid_i = 4'b0010;
    wait_grant(1, "rst_pre_grant");
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    set_op(1, 8'h40, 8'h40, 4'b0000);
    set_op(2, 8'h01, 8'h01, 4'b0000);
    req_valid_i = 4'b0110;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_mid_alu_a", 32'(alu_a_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_first_grant", 32'(req_ready_o), 32'b0010);
    sb_q.push_back({2'd1, 8'h80, 1'b0, 1'b1, 1'b0});
    @(posedge clk_i); #1;
    req_valid_i = '0;
    drain("rst_drain");

    // Non-arithmetic ops mask the flag pins; SUB to zero sets ZERO.
    issue(1, 8'h0F, 8'hF0, 4'b0100, {2'd1, 8'h00, 1'b0, 1'b0, 1'b0}, "and_grant");
    issue(0, 8'h0F, 8'hF0, 4'b0101, {2'd0, 8'hFF, 1'b0, 1'b0, 1'b0}, "or_grant");
    issue(2, 8'h05, 8'h05, 4'b0001, {2'd2, 8'h00, 1'b1, 1'b0, 1'b1}, "sub_grant");

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
